// File: rtl/palette_pkg.sv
// Shared types and constants for the palette copy engine.
package palette_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned CH_W        = 5;
    localparam int unsigned R_LSB       = 0;
    localparam int unsigned G_LSB       = 5;
    localparam int unsigned B_LSB       = 10;
    localparam int unsigned FLAG_BIT    = 15;
    localparam int unsigned PAL_ENTRIES = 1024;
    localparam int unsigned IDX_W       = 10;
    localparam int unsigned PAL_AW      = 11;

    // Palette CPU port addresses 16-bit words on even byte addresses.
    function automatic logic [PAL_AW-1:0] pal_word_addr_of(input logic [IDX_W-1:0] index);
        return {index, 1'b0};
    endfunction

endpackage

// File: rtl/palette_scale.sv
// Per-channel brightness scaler: (chan * (bright + 1)) >> 5.
module palette_scale
    import palette_pkg::*;
(
    input  logic [CH_W-1:0] chan,
    input  logic [4:0]      bright,
    output logic [CH_W-1:0] scaled_c
);

    logic [10:0] product;

    // bright+1 spans 1..32, so bright=31 is the identity and bright=0 gives zero.
    always_comb begin
        product  = 11'(chan) * 11'({1'b0, bright} + 6'd1);
        scaled_c = CH_W'(product >> 5);
    end

endmodule

// File: rtl/palette_dma.sv
// Copies COUNT source words into one palette bank, scaling each colour channel.
module palette_dma
    import palette_pkg::*;
#(
    parameter int unsigned SRC_AW = 20,
    parameter int unsigned COUNT  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic              dst_bank,
    input  logic [4:0]        bright,
    output logic              busy,
    output logic              done,
    output logic              src_req,
    output logic [SRC_AW-1:0] src_addr,
    input  logic              src_ack,
    input  logic [15:0]       src_data,
    output logic              pal_bank,
    output logic [1:0]        pal_we,
    output logic [10:0]       pal_word_addr,
    output logic [15:0]       pal_data
);

    localparam int unsigned LAST = COUNT - 1;

    state_t            state;
    logic [SRC_AW-1:0] base_q;
    logic              bank_q;
    logic [4:0]        bright_q;
    logic [IDX_W-1:0]  index;
    logic [CH_W-1:0]   r_c;
    logic [CH_W-1:0]   g_c;
    logic [CH_W-1:0]   b_c;

    palette_scale u_scale_r (
        .chan     (src_data[R_LSB +: CH_W]),
        .bright   (bright_q),
        .scaled_c (r_c)
    );

    palette_scale u_scale_g (
        .chan     (src_data[G_LSB +: CH_W]),
        .bright   (bright_q),
        .scaled_c (g_c)
    );

    palette_scale u_scale_b (
        .chan     (src_data[B_LSB +: CH_W]),
        .bright   (bright_q),
        .scaled_c (b_c)
    );

    // Transfer sequencer; every output is registered and the scaled word is captured on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            base_q        <= '0;
            bank_q        <= 1'b0;
            bright_q      <= '0;
            index         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            src_req       <= 1'b0;
            src_addr      <= '0;
            pal_bank      <= 1'b0;
            pal_we        <= 2'b00;
            pal_word_addr <= '0;
            pal_data      <= '0;
        end else begin
            done   <= 1'b0;
            pal_we <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= src_base;
                        bank_q   <= dst_bank;
                        bright_q <= bright;
                        index    <= '0;
                        src_addr <= src_base;
                        src_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (src_ack) begin
                        src_req       <= 1'b0;
                        pal_data      <= {src_data[FLAG_BIT], b_c, g_c, r_c};
                        pal_word_addr <= pal_word_addr_of(index);
                        pal_bank      <= bank_q;
                        pal_we        <= 2'b11;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (index == IDX_W'(LAST)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        index    <= index + IDX_W'(1);
                        src_addr <= base_q + SRC_AW'(index) + SRC_AW'(1);
                        src_req  <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_dma.sv
// Scoreboard bench for palette_dma with a randomized source responder.
module tb_palette_dma;

    localparam int unsigned SRC_AW = 20;
    localparam int unsigned COUNT  = 1024;

    typedef struct packed {
        logic        bank;
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SRC_AW-1:0] src_base;
    logic              dst_bank;
    logic [4:0]        bright;
    logic              busy;
    logic              done;
    logic              src_req;
    logic [SRC_AW-1:0] src_addr;
    logic              src_ack = 1'b0;
    logic [15:0]       src_data = 16'h0;
    logic              pal_bank;
    logic [1:0]        pal_we;
    logic [10:0]       pal_word_addr;
    logic [15:0]       pal_data;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int done_count = 0;
    int wr0 = 0;
    int done0 = 0;
    int src_mode = 0;
    int stall_max = 0;
    bit ack_noise = 1'b0;
    logic [SRC_AW-1:0] cur_base = '0;

    wr_t               exp_q[$];
    logic [SRC_AW-1:0] addr_q[$];

    bit                req_seen = 1'b0;
    int                stall = 0;
    logic [SRC_AW-1:0] held_addr = '0;

    palette_dma #(.SRC_AW(SRC_AW), .COUNT(COUNT)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_base      (src_base),
        .dst_bank      (dst_bank),
        .bright        (bright),
        .busy          (busy),
        .done          (done),
        .src_req       (src_req),
        .src_addr      (src_addr),
        .src_ack       (src_ack),
        .src_data      (src_data),
        .pal_bank      (pal_bank),
        .pal_we        (pal_we),
        .pal_word_addr (pal_word_addr),
        .pal_data      (pal_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Source buffer contents as a function of absolute word address.
    function automatic logic [15:0] src_word(input logic [SRC_AW-1:0] addr);
        logic [31:0] h;
        case (src_mode)
            0: src_word = 16'(addr - cur_base) ^ 16'h5A5A;
            1: src_word = 16'h7FFF;
            2: src_word = 16'h8000;
            default: begin
                h = 32'(addr) * 32'h9E3779B1;
                src_word = h[31:16];
            end
        endcase
    endfunction

    // Reference brightness: each channel times (bright+1), divided by 32.
    function automatic logic [15:0] scale_ref(input logic [15:0] w, input int br);
        int r, g, b;
        r = int'(w[4:0])   * (br + 1) / 32;
        g = int'(w[9:5])   * (br + 1) / 32;
        b = int'(w[14:10]) * (br + 1) / 32;
        return {w[15], b[4:0], g[4:0], r[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_transfer(input logic [SRC_AW-1:0] base, input logic bank, input logic [4:0] br);
        wr_t e;
        logic [SRC_AW-1:0] a;
        cur_base = base;
        for (int i = 0; i < int'(COUNT); i++) begin
            a = base + SRC_AW'(i);
            e.bank = bank;
            e.addr = 11'(i * 2);
            e.data = scale_ref(src_word(a), int'(br));
            exp_q.push_back(e);
            addr_q.push_back(a);
        end
    endtask

    task automatic issue_start(input logic [SRC_AW-1:0] base, input logic bank, input logic [4:0] br);
        src_base = base;
        dst_bank = bank;
        bright   = br;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_req", 32'(src_req), 32'd1);
    endtask

    task automatic wait_done(input int inject_at);
        bit inj;
        inj = 1'b0;
        for (int c = 0; c < int'(COUNT) * 10; c++) begin
            if (done === 1'b1) break;
            if (inject_at >= 0 && !inj && (wr_count - wr0) >= inject_at) begin
                src_base = src_base ^ 20'hABCDE;
                dst_bank = ~dst_bank;
                bright   = bright ^ 5'h0A;
                start    = 1'b1;
                inj      = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic at_done_checks();
        check("done_busy", 32'(busy), 32'd1);
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("reqs_left", 32'(addr_q.size()), 32'd0);
        check("write_count", 32'(wr_count - wr0), 32'(COUNT));
    endtask

    task automatic post_done_checks();
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_count", 32'(done_count - done0), 32'd1);
    endtask

    task automatic run_transfer(input logic [SRC_AW-1:0] base, input logic bank,
                                input logic [4:0] br, input int inject_at);
        wr0   = wr_count;
        done0 = done_count;
        expect_transfer(base, bank, br);
        issue_start(base, bank, br);
        wait_done(inject_at);
        at_done_checks();
        tick();
        post_done_checks();
    endtask

    // Source responder: random stalls, address checks, optional stray acks.
    always @(negedge clk) begin
        src_ack  = 1'b0;
        src_data = 16'($urandom);
        if (src_req === 1'b1 && reset === 1'b0) begin
            if (!req_seen) begin
                req_seen  = 1'b1;
                held_addr = src_addr;
                stall     = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL src_req_unexpected: got addr 0x%0h, required no request", src_addr);
                end else begin
                    check("src_addr_seq", 32'(src_addr), 32'(addr_q.pop_front()));
                end
            end else begin
                check("src_addr_hold", 32'(src_addr), 32'(held_addr));
            end
            if (stall == 0) begin
                src_ack  = 1'b1;
                src_data = src_word(src_addr);
                req_seen = 1'b0;
            end else begin
                stall--;
            end
        end else begin
            req_seen = 1'b0;
            if (ack_noise && $urandom_range(0, 3) == 0) src_ack = 1'b1;
        end
    end

    // Write monitor: every palette write is popped from the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (pal_we !== 2'b00) begin
            wr_count++;
            check("pal_we", 32'(pal_we), 32'd3);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pal_write_unexpected: got write addr 0x%0h data 0x%0h, required no write",
                         pal_word_addr, pal_data);
            end else begin
                e = exp_q.pop_front();
                check("pal_bank", 32'(pal_bank), 32'(e.bank));
                check("pal_word_addr", 32'(pal_word_addr), 32'(e.addr));
                check("pal_data", 32'(pal_data), 32'(e.data));
            end
        end
        if (done === 1'b1) done_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SRC_AW-1:0] b;
        logic              k;
        logic [4:0]        br;

        reset    = 1'b1;
        start    = 1'b0;
        src_base = '0;
        dst_bank = 1'b0;
        bright   = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_src_req", 32'(src_req), 32'd0);
        check("rst_pal_we", 32'(pal_we), 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        check("rst_pal_addr", 32'(pal_word_addr), 32'd0);
        check("rst_pal_data", 32'(pal_data), 32'd0);
        check("rst_pal_bank", 32'(pal_bank), 32'd0);
        reset = 1'b0;
        tick();

        // Identity brightness, index-derived data, zero-wait acks.
        src_mode = 0; stall_max = 0; ack_noise = 1'b0;
        run_transfer(20'h00100, 1'b1, 5'd31, -1);

        // Half brightness on full-white and flag-only words.
        src_mode = 1;
        run_transfer(SRC_AW'($urandom), 1'b0, 5'd15, -1);
        src_mode = 2;
        run_transfer(SRC_AW'($urandom), 1'b1, 5'd15, -1);

        // Random data, random stalls and stray acks outside REQ.
        src_mode = 3; stall_max = 5; ack_noise = 1'b1;
        run_transfer(SRC_AW'($urandom), 1'($urandom), 5'($urandom), -1);

        // Start while busy at entry 300 must be dropped; bright=0 blanks colour.
        stall_max = 2; ack_noise = 1'b0;
        run_transfer(SRC_AW'($urandom), 1'b0, 5'd0, 300);

        // Reset after entry 499 is written.
        stall_max = 3;
        wr0   = wr_count;
        done0 = done_count;
        b = SRC_AW'($urandom);
        expect_transfer(b, 1'b1, 5'd20);
        issue_start(b, 1'b1, 5'd20);
        for (int c = 0; c < int'(COUNT) * 10; c++) begin
            if (wr_count - wr0 >= 500) break;
            tick();
        end
        check("rst_mid_written", 32'(wr_count - wr0), 32'd500);
        reset = 1'b1;
        tick();
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_req", 32'(src_req), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_pending", 32'(exp_q.size()), 32'(COUNT - 500));
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (20) tick();
        check("rst_no_done", 32'(done_count - done0), 32'd0);
        check("rst_no_writes", 32'(wr_count - wr0), 32'd500);
        run_transfer(SRC_AW'($urandom), 1'b1, 5'($urandom), -1);

        // Source address wraps at the top of the address space.
        src_mode = 0; stall_max = 1;
        run_transfer(20'hFFFFC, 1'b0, 5'($urandom), -1);

        // Start held through DONE (ignored) into the first IDLE cycle (accepted).
        src_mode = 3; stall_max = 0;
        wr0   = wr_count;
        done0 = done_count;
        b = SRC_AW'($urandom);
        expect_transfer(b, 1'b0, 5'd7);
        issue_start(b, 1'b0, 5'd7);
        wait_done(-1);
        at_done_checks();
        src_base = b ^ 20'h55555;
        dst_bank = 1'b1;
        bright   = 5'd0;
        start    = 1'b1;
        tick();
        post_done_checks();
        wr0   = wr_count;
        done0 = done_count;
        b  = SRC_AW'($urandom);
        k  = 1'($urandom);
        br = 5'($urandom);
        expect_transfer(b, k, br);
        src_base = b;
        dst_bank = k;
        bright   = br;
        tick();
        start = 1'b0;
        check("idle_start_busy", 32'(busy), 32'd1);
        check("idle_start_req", 32'(src_req), 32'd1);
        wait_done(-1);
        at_done_checks();
        tick();
        post_done_checks();

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/palette_dma.md
# palette_dma

Copy engine that fills one 1024-entry palette bank from a work-RAM source buffer with a global brightness scale applied on the way. It drives the CPU-side write port of the palette RAM, acting as the writer while video scan-out reads the other bank. It sits between the sprite/tile DMA arbiter, which owns the source RAM request line, and the palette RAM.

## Interface
Parameters:
- SRC_AW, 20, source word-address width
- COUNT, 1024, entries copied per transfer (1..1024)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- src_base  in  SRC_AW  source word address of entry 0; latched on accepted start
- dst_bank  in  1  palette bank to write; latched on accepted start
- bright  in  5  brightness 0..31, where 31 is identity; latched on accepted start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last write
- src_req  out  1  source read request; held until ack
- src_addr  out  SRC_AW  source word address
- src_ack  in  1  source data valid this cycle
- src_data  in  16  source word: {x, B[14:10], G[9:5], R[4:0]}
- pal_bank  out  1  palette bank select
- pal_we  out  2  byte write enables to the palette CPU port
- pal_word_addr  out  11  palette CPU address {index[9:0], 1'b0}; bit 0 is always 0
- pal_data  out  16  scaled colour word

## Operation
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - start=1 latches src_base, dst_bank and bright, clears index to 0, and moves to REQ.
- REQ:
  - src_req=1, src_addr = (base + index) mod 2^SRC_AW.
  - src_ack=1 captures src_data and moves to WRITE.
  - src_ack while not in REQ is ignored.
- WRITE:
  - pal_we=2'b11 for exactly one cycle.
  - pal_word_addr={index,1'b0}, pal_bank=latched bank.
  - If index==COUNT-1, move to DONE; otherwise index+1 and return to REQ.
- DONE:
  - done=1 for one cycle, then back to IDLE.
- Scaling, applied per channel c∈{R,G,B}:
  - c' = (c × (bright+1)) >> 5, using an 11-bit product truncated to 5 bits.
  - bright=31 gives c'=c; bright=0 gives 0.
  - Bit 15 passes through unchanged.
- busy=1 in REQ, WRITE and DONE.
- start while busy is dropped; it is not queued. Inputs changed mid-transfer have no effect.
- src_base near the top of the address range wraps modulo 2^SRC_AW.

## Timing
- Reset values: state IDLE; busy, done, src_req and pal_we all 0; src_addr, pal_word_addr, pal_data and pal_bank all 0.
- Reset asserted mid-transfer:
  - Return to IDLE the next cycle with no further writes and no done pulse.
  - Entries already written stay written.
- start accepted at edge N: src_req=1 from cycle N+1.
- src_ack at cycle M: write in cycle M+1.
- Minimum rate is 2 cycles per entry (ack in the first REQ cycle). A full transfer with zero wait takes 2×COUNT cycles, with done in cycle 2×COUNT+1 after start.
- The scaling multiply is registered at the ack capture, so pal_data is stable throughout the WRITE cycle.
- start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.

## Structure
- Shared package (palette_pkg): state enum, colour field bit positions, PAL_ENTRIES=1024, and the pal_word_addr construction function.
- One sub-module, palette_scale: combinational 5-bit × 6-bit channel scaler, instantiated three times.

## Test plan
- bright=31, src_base=0x100, dst_bank=1, src_ack one cycle after each src_req, source word = index ^ 0x5A5A → palette bank 1 entry i = i^0x5A5A for all 1024 entries; one done pulse; busy low afterwards.
- bright=15, source 0x7FFF → every pal_data = 0x3DEF (each channel 31×16>>5 = 15, bit 15 = 0); source 0x8000 → 0x8000.
- Random 0–5 cycle ack stalls → src_addr held stable while src_req is high; exactly 1024 pal_we pulses; addresses 0x000, 0x002, … 0x7FE in order.
- start pulsed at entry 300 with different src_base and bank → ignored; transfer completes with the original parameters.
- reset at entry 500 → next cycle busy=0 and no done; entries ≥500 are not written; a fresh start then copies all 1024 entries.
- src_base = 2^SRC_AW − 4 → src_addr sequence …FFFC, …FFFD, …FFFE, …FFFF, 0, 1, …
